reg_hazard_scoreboard: RTL

- Tracks destination registers of in-flight instructions between decode and writeback.
- Produces the `is_full_rnum1` / `is_full_rnum2` hazard flags that the control path uses to insert a nop stall.
- Sits directly upstream of the control path, at the decode stage: it compares the source register numbers (rs, rt) of the decoding instruction against a shift pipeline of pending writes.

---
 rtl/reg_hazard_scoreboard.sv | 79 +++++++
 1 files changed

// File: rtl/reg_hazard_scoreboard.sv
// rtl/reg_hazard_scoreboard.sv - decode-stage pending-write scoreboard raising rs/rt hazard flags (optional macro: SCOREBOARD_WB_BYPASS_EN)
module reg_hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic                flush,
  input  logic [REG_BITS-1:0] rs_num,
  input  logic [REG_BITS-1:0] rt_num,
  output logic                is_full_rnum1,
  output logic                is_full_rnum2,
  output logic [3:0]          pending_count
);

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The writeback entry is skipped: the register file writes in the first
  // half-cycle, so a reader in the same cycle already sees the new value.
  localparam int NCMP = DEPTH - 1;
`else
  localparam int NCMP = DEPTH;
`endif

  // Entry 0 is the youngest write, entry DEPTH-1 is in its writeback cycle.
  logic [DEPTH-1:0]               v_q;
  logic [DEPTH-1:0][REG_BITS-1:0] rd_q;

  logic       ins;
  logic [3:0] cnt_next;
  logic       hit1;
  logic       hit2;

  // r0 is hardwired, so writes to it never make anything busy.
  assign ins = issue_valid & issue_wr & ~flush & (issue_rd != '0);

  // Pending count tracks one insert and one retire per cycle; both cancel.
  always_comb begin
    cnt_next = pending_count;
    if (ins && !v_q[DEPTH-1]) begin
      cnt_next = pending_count + 4'd1;
    end else if (!ins && v_q[DEPTH-1]) begin
      cnt_next = pending_count - 4'd1;
    end
  end

  // Shift pipeline: advances every cycle, bubbles drain pending writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q           <= '0;
      rd_q          <= '0;
      pending_count <= 4'd0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_q[i]  <= v_q[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      v_q[0]        <= ins;
      rd_q[0]       <= issue_rd;
      pending_count <= cnt_next;
    end
  end

  // Hazard lookup against current entries only, so an instruction never
  // hazards on its own destination in the cycle it issues.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      if (v_q[i] && (rd_q[i] == rs_num)) hit1 = 1'b1;
      if (v_q[i] && (rd_q[i] == rt_num)) hit2 = 1'b1;
    end
    is_full_rnum1 = hit1 & (rs_num != '0);
    is_full_rnum2 = hit2 & (rt_num != '0);
  end

endmodule
